// File: rtl/timer_scheduler.sv
// timer_scheduler: a single countdown timer shared round-robin by NREQ
// requesters. An idle timer grants the next pending requester, loads that
// requester's reload value, counts down to zero and signals done to the owner.
// Optional feature macro: TIMER_SCHED_ABORT_EN adds an abort input that cancels
// a running countdown without producing done.
module timer_scheduler #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*WIDTH-1:0]     req_div,
`ifdef TIMER_SCHED_ABORT_EN
  input  logic                      abort,
`endif
  output logic [NREQ-1:0]           grant,
  output logic [NREQ-1:0]           done,
  output logic                      busy,
  output logic [$clog2(NREQ)-1:0]   owner
);

  localparam int OW = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   cnt_q;
  logic [NREQ-1:0]    grant_q;
  logic [NREQ-1:0]    done_q;
  logic               busy_q;
  logic [OW-1:0]      owner_q;
  // Last granted index; the arbitration search begins one past it.
  logic [OW-1:0]      rr_last_q;

  logic [WIDTH-1:0]   div_arr [NREQ];
  logic [OW:0]        pick;
  logic               win_vld;
  logic [OW-1:0]      win_idx;
  logic               abort_act;

  // Decrement that holds at zero so the counter can never wrap.
  function automatic logic [WIDTH-1:0] sat_dec(input logic [WIDTH-1:0] v);
    return (v == '0) ? v : v - 1'b1;
  endfunction

  // One-hot vector with bit idx set.
  function automatic logic [NREQ-1:0] onehot(input logic [OW-1:0] idx);
    logic [NREQ-1:0] res;
    res      = '0;
    res[idx] = 1'b1;
    return res;
  endfunction

  // Round-robin pick: {valid, index}. Candidates are visited from farthest to
  // nearest so the requester closest after 'last' overwrites the others.
  function automatic logic [OW:0] rr_pick(input logic [NREQ-1:0] r,
                                          input logic [OW-1:0]   last);
    logic [OW:0]   res;
    logic [OW-1:0] cand;
    int            cand_i;
    res = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand_i = (int'(last) + k) % NREQ;
      cand   = cand_i[OW-1:0];
      if (r[cand]) res = {1'b1, cand};
    end
    return res;
  endfunction

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign div_arr[gi] = req_div[gi*WIDTH +: WIDTH];
  end

`ifdef TIMER_SCHED_ABORT_EN
  assign abort_act = abort;
`else
  assign abort_act = 1'b0;
`endif

  // Arbitration: choose the next requester after the last owner.
  always_comb begin
    pick    = rr_pick(req, rr_last_q);
    win_vld = pick[OW];
    win_idx = pick[OW-1:0];
  end

  // Control FSM with registered grant/done/busy/owner outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      busy_q    <= 1'b0;
      owner_q   <= '0;
      rr_last_q <= OW'(NREQ - 1);
    end else begin
      grant_q <= '0;
      done_q  <= '0;
      case (state_q)
        S_IDLE: begin
          if (win_vld) begin
            state_q   <= S_COUNT;
            cnt_q     <= div_arr[win_idx];
            owner_q   <= win_idx;
            rr_last_q <= win_idx;
            grant_q   <= onehot(win_idx);
            busy_q    <= 1'b1;
          end
        end
        S_COUNT: begin
          if (abort_act) begin
            // Cancelled: drop the delay silently; rr_last_q already points at
            // the owner, so the next search starts past it.
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_q == '0) begin
            state_q <= S_DONE;
            done_q  <= onehot(owner_q);
          end else begin
            cnt_q <= sat_dec(cnt_q);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign owner = owner_q;

endmodule

// File: tb/tb_timer_scheduler.sv
// Bench for timer_scheduler (NREQ=4, WIDTH=8). Expected grants are queued when
// a request is driven; a negedge monitor pops them on grant and checks the
// done cycle, one-hot outputs, owner and busy.
module tb_timer_scheduler;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] req_div = '0;
  logic                  abort = 1'b0;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       done;
  logic                  busy;
  logic [1:0]            owner;

  timer_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .req_div (req_div),
`ifdef TIMER_SCHED_ABORT_EN
    .abort   (abort),
`endif
    .grant   (grant),
    .done    (done),
    .busy    (busy),
    .owner   (owner)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int idx;
    int d;
  } exp_t;

  exp_t exp_q[$];

  typedef struct {
    logic [3:0]  m;
    logic [31:0] dv;
    int          idx;
    int          d;
  } vec_t;

  vec_t tbl [9];

  int cyc      = 0;
  bit pend_vld = 1'b0;
  int pend_idx = 0;
  int pend_due = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (grant !== '0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_grant", 64'(grant), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("grant_onehot", 64'(grant), 64'(1 << e.idx));
        chk("grant_owner", 64'(owner), 64'(e.idx));
        chk("grant_done_excl", 64'(done), 64'd0);
        pend_vld = 1'b1;
        pend_idx = e.idx;
        pend_due = cyc + e.d + 1;
      end
    end
    chk("busy", 64'(busy), 64'(pend_vld));
    if (done !== '0) begin
      if (!pend_vld) begin
        chk("unexpected_done", 64'(done), 64'd0);
      end else begin
        chk("done_onehot", 64'(done), 64'(1 << pend_idx));
        chk("done_cycle", 64'(cyc), 64'(pend_due));
        chk("done_owner", 64'(owner), 64'(pend_idx));
        pend_vld = 1'b0;
      end
    end else if (pend_vld && cyc > pend_due) begin
      chk("done_timeout", 64'(cyc), 64'(pend_due));
      pend_vld = 1'b0;
    end
    if (rst || abort) pend_vld = 1'b0;
  end

  task automatic push_exp(input int idx, input int d);
    exp_t e;
    e.idx = idx;
    e.d   = d;
    exp_q.push_back(e);
  endtask

  task automatic wait_grant(input string nm);
    bit got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (grant !== '0) got = 1'b1;
    end
    chk({nm, "_grant_seen"}, 64'(got), 64'd1);
    if (!got) exp_q.delete();
  endtask

  task automatic wait_idle(input string nm);
    bit idle = 1'b0;
    for (int i = 0; i < 400 && !idle; i++) begin
      @(negedge clk);
      if (busy === 1'b0) idle = 1'b1;
    end
    chk({nm, "_idle_seen"}, 64'(idle), 64'd1);
  endtask

  task automatic check_zero(input string nm);
    @(negedge clk);
    chk({nm, "_grant"}, 64'(grant), 64'd0);
    chk({nm, "_done"},  64'(done),  64'd0);
    chk({nm, "_busy"},  64'(busy),  64'd0);
    chk({nm, "_owner"}, 64'(owner), 64'd0);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst = 1'b1;
    req = '0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Drive one request set, drop it (and scramble reload values) right after
  // the grant, then wait for the timer to go idle.
  task automatic run_txn(input logic [3:0] m, input logic [31:0] dv,
                         input int idx, input int d);
    push_exp(idx, d);
    @(posedge clk); #1;
    req     = m;
    req_div = dv;
    wait_grant("txn");
    @(posedge clk); #1;
    req     = '0;
    req_div = 32'h0909_0909;
    wait_idle("txn");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // {req mask, {D3,D2,D1,D0}, expected winner, expected D}
    tbl[0] = '{4'b0100, {8'd0,   8'd5, 8'd0, 8'd0}, 2, 5};
    tbl[1] = '{4'b0001, {8'd0,   8'd0, 8'd0, 8'd0}, 0, 0};
    tbl[2] = '{4'b0010, {8'd0,   8'd0, 8'd3, 8'd0}, 1, 3};
    tbl[3] = '{4'b1111, {8'd4,   8'd2, 8'd6, 8'd1}, 2, 2};
    tbl[4] = '{4'b1011, {8'd3,   8'd0, 8'd1, 8'd2}, 3, 3};
    tbl[5] = '{4'b1011, {8'd3,   8'd0, 8'd1, 8'd2}, 0, 2};
    tbl[6] = '{4'b1001, {8'd1,   8'd0, 8'd0, 8'd4}, 3, 1};
    tbl[7] = '{4'b1000, {8'd255, 8'd0, 8'd0, 8'd0}, 3, 255};
    tbl[8] = '{4'b1010, {8'd0,   8'd0, 8'd7, 8'd0}, 1, 7};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_zero("reset");

    for (int i = 0; i < 9; i++) begin
      run_txn(tbl[i].m, tbl[i].dv, tbl[i].idx, tbl[i].d);
    end

    // Fairness: all four held with D=1 after reset -> 0,1,2,3,0.
    do_reset(2);
    check_zero("reset2");
    push_exp(0, 1); push_exp(1, 1); push_exp(2, 1); push_exp(3, 1); push_exp(0, 1);
    @(posedge clk); #1;
    req     = 4'b1111;
    req_div = {4{8'd1}};
    begin
      int ng = 0;
      for (int i = 0; i < 80 && ng < 5; i++) begin
        @(negedge clk);
        if (grant !== '0) ng++;
      end
      chk("fair_grant_count", 64'(ng), 64'd5);
    end
    @(posedge clk); #1;
    req = '0;
    wait_idle("fair");

    // Reset in the middle of a long countdown; afterwards 0 beats 1.
    push_exp(1, 100);
    @(posedge clk); #1;
    req     = 4'b0010;
    req_div = {8'd0, 8'd0, 8'd100, 8'd0};
    wait_grant("rstmid");
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst     = 1'b0;
    req     = 4'b0011;
    req_div = {8'd0, 8'd0, 8'd100, 8'd2};
    push_exp(0, 2);
    check_zero("rstmid_after");
    wait_grant("rstmid_next");
    @(posedge clk); #1;
    req = '0;
    wait_idle("rstmid_next");

`ifdef TIMER_SCHED_ABORT_EN
    // Abort four cycles into a 50-cycle delay; req[0] is then served.
    do_reset(2);
    push_exp(3, 50);
    @(posedge clk); #1;
    req     = 4'b1000;
    req_div = {8'd50, 8'd0, 8'd0, 8'd0};
    wait_grant("abort");
    @(posedge clk); #1;
    req = '0;
    repeat (3) @(posedge clk);
    #1;
    abort   = 1'b1;
    req     = 4'b0001;
    req_div = {8'd50, 8'd0, 8'd0, 8'd2};
    push_exp(0, 2);
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_busy_low", 64'(busy), 64'd0);
    wait_grant("abort_next");
    @(posedge clk); #1;
    req = '0;
    wait_idle("abort_next");
`endif

    repeat (3) @(negedge clk);
    chk("exp_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("no_pending_done", 64'(pend_vld), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
